// File: rtl/ysyx_25040118_lsu_pkg.sv
// Shared LSU definitions: funct3 size/sign codes and FSM state encoding.
package ysyx_25040118_lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/ysyx_25040118_lsu_align.sv
// Combinational byte-lane logic: store mask/replication, load extraction and
// extension, misalignment and undefined-size detection.
module ysyx_25040118_lsu_align
  import ysyx_25040118_lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misaligned,
  output logic        undef
);

  logic [1:0]  off;
  logic [31:0] shifted;

  // Low address bits below the access size are dropped, so a misaligned
  // access that is allowed onto the bus lands on the enclosing aligned lanes.
  always_comb begin
    off        = 2'b00;
    wmask      = 4'b1111;
    wdata_lane = wdata;
    misaligned = 1'b0;
    undef      = 1'b0;
    case (funct3)
      LSU_B, LSU_BU: begin
        off        = addr_lo;
        wmask      = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      LSU_H, LSU_HU: begin
        off        = {addr_lo[1], 1'b0};
        wmask      = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      LSU_W:   misaligned = |addr_lo;
      default: undef = 1'b1;
    endcase
  end

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    rdata_ext = rdata;
    case (funct3)
      LSU_B:   rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      LSU_BU:  rdata_ext = {24'd0, shifted[7:0]};
      LSU_H:   rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      LSU_HU:  rdata_ext = {16'd0, shifted[15:0]};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_25040118_lsu.sv
// Multi-cycle load/store unit: one operation per handshake, word-aligned bus
// request with byte mask, extended load data back to the EXU.
module ysyx_25040118_lsu
  import ysyx_25040118_lsu_pkg::*;
#(
  parameter bit MISALIGN_CHK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp_err
);

  lsu_state_e  state;
  logic        op_store;
  logic [2:0]  op_f3;
  logic [1:0]  op_off;

  logic [1:0]  al_addr;
  logic [2:0]  al_f3;
  logic [3:0]  al_wmask;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_mis;
  logic        al_undef;
  logic        reject;

  assign req_ready = (state == LSU_IDLE);

  // The lane logic sees the live request while idle and the latched op after.
  assign al_addr = req_ready ? req_addr[1:0] : op_off;
  assign al_f3   = req_ready ? req_funct3    : op_f3;
  assign reject  = al_undef | (MISALIGN_CHK & al_mis);

  ysyx_25040118_lsu_align u_align (
    .addr_lo    (al_addr),
    .funct3     (al_f3),
    .wdata      (req_wdata),
    .rdata      (mem_rdata),
    .wmask      (al_wmask),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_mis),
    .undef      (al_undef)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= LSU_IDLE;
      op_store      <= 1'b0;
      op_f3         <= 3'b000;
      op_off        <= 2'b00;
      resp_valid    <= 1'b0;
      resp_rdata    <= 32'd0;
      resp_err      <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_addr      <= 32'd0;
      mem_wen       <= 1'b0;
      mem_wdata     <= 32'd0;
      mem_wmask     <= 4'd0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (req_valid) begin
            op_store <= req_is_store;
            op_f3    <= req_funct3;
            op_off   <= req_addr[1:0];
            if (reject) begin
              state      <= LSU_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              state         <= LSU_REQ;
              mem_req_valid <= 1'b1;
              mem_addr      <= {req_addr[31:2], 2'b00};
              mem_wen       <= req_is_store;
              mem_wdata     <= req_is_store ? al_wdata : 32'd0;
              mem_wmask     <= al_wmask;
            end
          end
        end
        LSU_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= LSU_WAIT;
          end
        end
        LSU_WAIT: begin
          if (mem_resp_valid) begin
            resp_valid <= 1'b1;
            resp_rdata <= op_store ? 32'd0 : al_rdata;
            resp_err   <= mem_resp_err;
            state      <= LSU_RESP;
          end
        end
        LSU_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            state      <= LSU_IDLE;
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040118_lsu.sv
// Directed plus randomized bench for the LSU against a byte-level reference model.
module tb_ysyx_25040118_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        mem_resp_err;

  int n_chk  = 0;
  int n_fail = 0;
  int bus_hs = 0;
  int exp_hs = 0;

  logic [3:0]  last_wmask;
  logic [31:0] last_mwdata;
  logic [31:0] last_rdata;
  logic        last_err;

  ysyx_25040118_lsu #(.MISALIGN_CHK(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_is_store   (req_is_store),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .mem_resp_err   (mem_resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_req_valid && mem_req_ready) bus_hs <= bus_hs + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Access size in bytes; 0 marks an undefined funct3.
  function automatic int msize(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  req_ready, 1);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_rdata"}, resp_rdata, 0);
    check({tag, "_resp_err"},   resp_err, 0);
    check({tag, "_mreq_valid"}, mem_req_valid, 0);
    check({tag, "_mem_wen"},    mem_wen, 0);
    check({tag, "_mem_addr"},   mem_addr, 0);
    check({tag, "_mem_wdata"},  mem_wdata, 0);
    check({tag, "_mem_wmask"},  mem_wmask, 0);
  endtask

  // One complete operation: called at a negedge with the DUT idle, returns at
  // the negedge following the response handshake (DUT idle again).
  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input bit berr,
                       input int req_stall, input int resp_delay, input int rr_stall);
    int          s;
    int          off;
    bit          rej;
    logic [3:0]  e_mask;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    logic        e_err;
    longint      v;
    s   = msize(f3);
    rej = (s == 0) || ((a % s) != 0);
    off = (s == 0) ? 0 : ((a % 4) / s) * s;
    e_mask = (s == 0) ? 4'b1111 : 4'(((1 << s) - 1) << off);
    e_wd = 32'd0;
    if (st && s != 0)
      for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wd[8*(i % s) +: 8];
    if (rej) begin
      e_rd = 32'd0; e_err = 1'b1;
    end else if (st) begin
      e_rd = 32'd0; e_err = berr;
    end else begin
      v = (longint'(rd) >> (8 * off)) & ((64'sd1 <<< (8 * s)) - 1);
      if (!f3[2] && s < 4 && v >= (64'sd1 <<< (8 * s - 1))) v = v - (64'sd1 <<< (8 * s));
      e_rd = v[31:0]; e_err = berr;
    end

    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    if (!rej) begin
      exp_hs++;
      for (int i = 0; i <= req_stall; i++) begin
        if (i == req_stall) mem_req_ready = 1'b1;
        check("mem_req_valid", mem_req_valid, 1);
        check("mem_addr", mem_addr, {a[31:2], 2'b00});
        check("mem_wen", mem_wen, 32'(st));
        check("mem_wdata", mem_wdata, e_wd);
        check("mem_wmask", mem_wmask, 32'(e_mask));
        check("req_ready_busy", req_ready, 0);
        last_wmask = mem_wmask; last_mwdata = mem_wdata;
        @(negedge clk);
      end
      mem_req_ready = 1'b0;
      check("mem_req_drop", mem_req_valid, 0);
      for (int i = 0; i < resp_delay; i++) begin
        check("resp_valid_wait", resp_valid, 0);
        @(negedge clk);
      end
      mem_resp_valid = 1'b1; mem_rdata = rd; mem_resp_err = berr;
      @(negedge clk);
      mem_resp_valid = 1'b0; mem_rdata = $urandom; mem_resp_err = 1'b0;
    end else begin
      check("no_bus_on_reject", mem_req_valid, 0);
    end
    for (int i = 0; i <= rr_stall; i++) begin
      if (i == rr_stall) resp_ready = 1'b1;
      check("resp_valid", resp_valid, 1);
      check("resp_rdata", resp_rdata, e_rd);
      check("resp_err", resp_err, 32'(e_err));
      check("req_ready_resp", req_ready, 0);
      check("mem_idle_resp", mem_req_valid, 0);
      last_rdata = resp_rdata; last_err = resp_err;
      @(negedge clk);
    end
    resp_ready = 1'b0;
    check("resp_valid_clr", resp_valid, 0);
    check("req_ready_back", req_ready, 1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_rdata = 32'd0; mem_resp_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Zero-wait store word
    do_op(1'b1, 3'b010, 32'h8000_0104, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 0, 0);
    check("sw_wmask", last_wmask, 32'h0000_000F);
    check("sw_wdata", last_mwdata, 32'hDEAD_BEEF);
    check("sw_err", last_err, 0);

    // Byte loads at the top lane
    do_op(1'b0, 3'b000, 32'h8000_0103, 32'h0, 32'h80AA_BBCC, 1'b0, 0, 0, 0);
    check("lb_wmask", last_wmask, 32'h0000_0008);
    check("lb_rdata", last_rdata, 32'hFFFF_FF80);
    do_op(1'b0, 3'b100, 32'h8000_0103, 32'h0, 32'h80AA_BBCC, 1'b0, 0, 0, 0);
    check("lbu_rdata", last_rdata, 32'h0000_0080);

    // Halfword store upper lanes, misaligned halfword load
    do_op(1'b1, 3'b001, 32'h8000_0012, 32'h1234_ABCD, 32'h0, 1'b0, 0, 0, 0);
    check("sh_wmask", last_wmask, 32'h0000_000C);
    check("sh_wdata", last_mwdata, 32'hABCD_ABCD);
    do_op(1'b0, 3'b001, 32'h8000_0011, 32'h0, 32'h0, 1'b0, 0, 0, 0);
    check("lh_mis_err", last_err, 1);
    do_op(1'b0, 3'b110, 32'h8000_0020, 32'h0, 32'h0, 1'b0, 0, 0, 0);
    check("undef_err", last_err, 1);

    // Backpressure on both sides
    do_op(1'b0, 3'b101, 32'h8000_0042, 32'h0, 32'hF00D_1234, 1'b0, 3, 2, 2);
    check("lhu_bp_rdata", last_rdata, 32'h0000_F00D);

    // Bus error on a word load
    do_op(1'b0, 3'b010, 32'h8000_0100, 32'h0, 32'h1111_2222, 1'b1, 0, 0, 0);
    check("lw_bus_err", last_err, 1);

    // Reset while waiting for the bus response
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0200;
    @(negedge clk);
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; exp_hs++;
    check("wait_busy", req_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midrst");
    mem_resp_valid = 1'b1; mem_rdata = 32'h5555_AAAA; mem_resp_err = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    @(negedge clk);
    check("stale_resp_valid", resp_valid, 0);
    check("stale_req_ready", req_ready, 1);

    // Back-to-back load then store
    do_op(1'b0, 3'b010, 32'h8000_0300, 32'h0, 32'hCAFE_F00D, 1'b0, 0, 0, 0);
    check("b2b_lw_rdata", last_rdata, 32'hCAFE_F00D);
    do_op(1'b1, 3'b000, 32'h8000_0301, 32'h0000_00A5, 32'h0, 1'b0, 0, 0, 0);
    check("b2b_sb_wmask", last_wmask, 32'h0000_0002);
    check("b2b_sb_wdata", last_mwdata, 32'hA5A5_A5A5);

    // Randomized operations
    for (int k = 0; k < 40; k++) begin
      bit st;
      st = 1'($urandom_range(0, 1));
      do_op(st, st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7)), $urandom,
            $urandom, $urandom, 1'($urandom_range(0, 3) == 0),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    check("bus_handshakes", bus_hs, exp_hs);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
